// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// Command entries carry an accumulate flag only when ALU_ISSUER_ACC_EN is defined.
package alu_pkg;

  localparam int ALU_W    = 16;
  localparam int ALU_OP_W = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

  typedef struct packed {
`ifdef ALU_ISSUER_ACC_EN
    logic                acc;
`endif
    logic [ALU_OP_W-1:0] op;
    logic [ALU_W-1:0]    a;
    logic [ALU_W-1:0]    b;
  } alu_cmd_t;

`ifdef ALU_ISSUER_ACC_EN
  localparam int ALU_CMD_W = 35;
`else
  localparam int ALU_CMD_W = 34;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO for issuer commands; DEPTH must be a power of two so the
// pointers wrap naturally.
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Issues buffered commands to a combinational ALU and returns its result over
// a valid/ready response port. Define ALU_ISSUER_ACC_EN for accumulator operand.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ALU_OP_W-1:0]   cmd_op,
  input  logic [ALU_W-1:0]      cmd_a,
  input  logic [ALU_W-1:0]      cmd_b,
  input  logic                  cmd_acc,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [ALU_W-1:0]      alu_i0,
  output logic [ALU_W-1:0]      alu_i1,
  input  logic [ALU_W-1:0]      alu_o,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ALU_W-1:0]      rsp_data,
  output logic                  rsp_cout,
  output logic [$clog2(DEPTH):0] fifo_count
);

  issuer_state_e        state_q, state_d;
  alu_cmd_t             cmd_in, head;
  logic [ALU_CMD_W-1:0] head_raw;
  logic                 fifo_full, fifo_empty, fifo_pop, capture, rsp_valid_d;
  logic [ALU_W-1:0]     operand0;
  logic [ALU_OP_W-1:0]  alu_op_q;
  logic [ALU_W-1:0]     alu_i0_q, alu_i1_q, rsp_data_q;
  logic                 rsp_cout_q, rsp_valid_q;

  always_comb begin
    cmd_in    = '0;
    cmd_in.op = cmd_op;
    cmd_in.a  = cmd_a;
    cmd_in.b  = cmd_b;
`ifdef ALU_ISSUER_ACC_EN
    cmd_in.acc = cmd_acc;
`endif
  end

  alu_issue_fifo #(.DEPTH(DEPTH), .WIDTH(ALU_CMD_W)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (cmd_valid & cmd_ready),
    .push_data_i (cmd_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign cmd_ready = ~fifo_full;
  assign head      = alu_cmd_t'(head_raw);

`ifdef ALU_ISSUER_ACC_EN
  logic [ALU_W-1:0] acc_q;

  assign operand0 = head.acc ? acc_q : head.a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       acc_q <= '0;
    else if (capture) acc_q <= alu_o;
  end
`else
  logic unused_cmd_acc;

  assign unused_cmd_acc = cmd_acc;
  assign operand0       = head.a;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    capture     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        capture     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          fifo_pop    = ~fifo_empty;
          state_d     = fifo_empty ? ST_IDLE : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      alu_i0_q    <= '0;
      alu_i1_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (fifo_pop) begin
        alu_op_q <= head.op;
        alu_i0_q <= operand0;
        alu_i1_q <= head.b;
      end
      if (capture) begin
        rsp_data_q <= alu_o;
        rsp_cout_q <= alu_cout;
      end
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_i0    = alu_i0_q;
  assign alu_i1    = alu_i1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed self-checking bench for alu_issuer with a behavioural ALU model.
module tb_alu_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_acc = 1'b0;
  logic [1:0]  cmd_op = '0, alu_op;
  logic [15:0] cmd_a = '0, cmd_b = '0, alu_i0, alu_i1, alu_o, rsp_data;
  logic        alu_cout, rsp_valid, rsp_ready = 1'b1, rsp_cout;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  alu_issuer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_op(alu_op), .alu_i0(alu_i0), .alu_i1(alu_i1),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    {alu_cout, alu_o} = 17'h0;
    case (alu_op)
      ALU_ADD: {alu_cout, alu_o} = {1'b0, alu_i0} + {1'b0, alu_i1};
      ALU_SUB: {alu_cout, alu_o} = {1'b0, alu_i0} - {1'b0, alu_i1};
      ALU_AND: alu_o = alu_i0 & alu_i1;
      default: alu_o = alu_i0 | alu_i1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
    check("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_acc = 1'b0;
  endtask

  // Waits for a response, compares it, then consumes it with rsp_ready high.
  task automatic expect_rsp(input string tag, input logic [15:0] data, input logic cout,
                            output int edges);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, data});
    check({tag, "_cout"}, {31'd0, rsp_cout}, {31'd0, cout});
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic first_test(input string tag);
    int n;
    rsp_ready = 1'b1;
    send(ALU_ADD, 16'hffff, 16'h0001, 1'b0);
    check({tag, "_cnt_after_push"}, {29'd0, fifo_count}, 32'd1);
    expect_rsp(tag, 16'h0000, 1'b1, n);
    check({tag, "_latency"}, n + 1, 32'd3);
  endtask

  initial begin
    int n, accepted, seen;

    #2;
    check("rst_alu_op", {30'd0, alu_op}, 32'd0);
    check("rst_alu_i0", {16'd0, alu_i0}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    reset = 1'b1;
    tick();

    first_test("add_wrap");

    send(ALU_AND, 16'haa55, 16'h55aa, 1'b0);
    expect_rsp("and", 16'h0000, 1'b0, n);
    send(ALU_OR, 16'haa55, 16'h55aa, 1'b0);
    expect_rsp("or", 16'hffff, 1'b0, n);
    send(ALU_SUB, 16'h0005, 16'h0003, 1'b0);
    expect_rsp("sub", 16'h0002, 1'b0, n);

    // Back-pressure: fill the FIFO with rsp_ready low.
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1; cmd_op = ALU_ADD;
      cmd_a = 16'h1000 + 16'(accepted); cmd_b = 16'(accepted);
      if (cmd_ready) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", accepted, 32'd5);
    check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("bp_fifo_count", {29'd0, fifo_count}, 32'd4);
    for (int i = 0; i < 10; i++) tick();
    check("hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("hold_data", {16'd0, rsp_data}, 32'h1000);
    check("hold_cout", {31'd0, rsp_cout}, 32'd0);
    check("hold_alu_i0", {16'd0, alu_i0}, 32'h1000);
    check("hold_alu_i1", {16'd0, alu_i1}, 32'h0000);

    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("drain%0d_data", k), {16'd0, rsp_data}, 32'h1000 + 2 * k);
      tick();
      check($sformatf("drain%0d_gap", k), {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("drain_empty", {29'd0, fifo_count}, 32'd0);
    check("drain_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Reach WAIT with three entries queued, then reset asynchronously.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(ALU_OR, 16'h0f00, 16'(i), 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("pre_rst_count", {29'd0, fifo_count}, 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_alu_op", {30'd0, alu_op}, 32'd0);
    check("arst_alu_i0", {16'd0, alu_i0}, 32'd0);
    check("arst_alu_i1", {16'd0, alu_i1}, 32'd0);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("arst_rsp_cout", {31'd0, rsp_cout}, 32'd0);
    check("arst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("post_rst_stale", seen, 32'd0);
    first_test("post_rst");

    send(ALU_ADD, 16'h0003, 16'h0004, 1'b0);
    expect_rsp("acc_first", 16'h0007, 1'b0, n);
    send(ALU_ADD, 16'h0100, 16'h0010, 1'b1);
`ifdef ALU_ISSUER_ACC_EN
    expect_rsp("acc_second", 16'h0017, 1'b0, n);
`else
    expect_rsp("acc_second", 16'h0110, 1'b0, n);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
